// File: rtl/maze_pkg.sv
// Shared maze constants, direction codes, round states and wall-index helpers.
package maze_pkg;

  localparam int MAZE_COLS = 10;
  localparam int MAZE_ROWS = 15;

  localparam int H_WALL_W   = (MAZE_ROWS + 1) * MAZE_COLS;
  localparam int V_WALL_W   = MAZE_ROWS * (MAZE_COLS + 1);
  localparam int WALL_IDX_W = $clog2((H_WALL_W > V_WALL_W) ? H_WALL_W : V_WALL_W);

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    GEN_RST,
    GEN_WAIT,
    PLAY,
    WON
  } state_e;

  typedef logic [WALL_IDX_W-1:0] wall_idx_t;

  // Index of the horizontal wall directly above cell (row, col).
  function automatic wall_idx_t h_wall_idx(input logic [3:0] row, input logic [3:0] col);
    return wall_idx_t'(int'(row) * MAZE_COLS + int'(col));
  endfunction

  // Index of the vertical wall directly left of cell (row, col).
  function automatic wall_idx_t v_wall_idx(input logic [3:0] row, input logic [3:0] col);
    return wall_idx_t'(int'(row) * (MAZE_COLS + 1) + int'(col));
  endfunction

endpackage

// File: rtl/maze_wall_lookup.sv
// Combinational move check: a move is blocked by a closed wall or by the grid edge.
module maze_wall_lookup
  import maze_pkg::*;
(
  input  logic [3:0]          row,
  input  logic [3:0]          col,
  input  logic [1:0]          dir,
  input  logic [H_WALL_W-1:0] h_walls,
  input  logic [V_WALL_W-1:0] v_walls,
  output logic                blocked
);

  // Edge check and wall bit are OR-ed so an open wall on the border never lets the player out.
  always_comb begin
    blocked = 1'b1;
    case (dir)
      DIR_UP:    blocked = (row == 4'd0) || h_walls[h_wall_idx(row, col)];
      DIR_DOWN:  blocked = (row == 4'(MAZE_ROWS - 1)) || h_walls[h_wall_idx(4'(row + 4'd1), col)];
      DIR_LEFT:  blocked = (col == 4'd0) || v_walls[v_wall_idx(row, col)];
      DIR_RIGHT: blocked = (col == 4'(MAZE_COLS - 1)) || v_walls[v_wall_idx(row, col) + wall_idx_t'(1)];
      default:   blocked = 1'b1;
    endcase
  end

endmodule

// File: rtl/maze_game_controller.sv
// Round sequencer: pulses the generator reset, waits for the maze, then runs player moves.
module maze_game_controller
  import maze_pkg::*;
#(
  parameter int COLS           = MAZE_COLS,
  parameter int ROWS           = MAZE_ROWS,
  parameter int GEN_RST_CYCLES = 4,
  parameter int CNT_W          = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       move_valid,
  input  logic [1:0]                 move_dir,
  input  logic                       gen_busy,
  input  logic [(ROWS+1)*COLS-1:0]   h_walls,
  input  logic [ROWS*(COLS+1)-1:0]   v_walls,
  output logic                       gen_rst,
  output logic                       ready,
  output logic [3:0]                 player_row,
  output logic [3:0]                 player_col,
  output logic [CNT_W-1:0]           move_count,
  output logic                       bump,
  output logic                       won
);

  localparam int GC_W = $clog2(GEN_RST_CYCLES + 1);
  localparam logic [GC_W-1:0] GC_LOAD = GC_W'(GEN_RST_CYCLES - 1);

  state_e           state_reg;
  logic [GC_W-1:0]  gen_cnt_reg;
  logic             settle_reg;
  logic             gen_rst_reg;
  logic             ready_reg;
  logic             won_reg;
  logic             bump_reg;
  logic [3:0]       row_reg;
  logic [3:0]       col_reg;
  logic [CNT_W-1:0] move_count_reg;

  logic             blocked;
  logic [3:0]       row_next;
  logic [3:0]       col_next;
  logic             at_exit;

  maze_wall_lookup u_wall_lookup (
    .row     (row_reg),
    .col     (col_reg),
    .dir     (move_dir),
    .h_walls (h_walls),
    .v_walls (v_walls),
    .blocked (blocked)
  );

  // Candidate position for the requested direction; only committed when the move is not blocked.
  always_comb begin
    row_next = row_reg;
    col_next = col_reg;
    case (move_dir)
      DIR_UP:    row_next = row_reg - 4'd1;
      DIR_DOWN:  row_next = row_reg + 4'd1;
      DIR_LEFT:  col_next = col_reg - 4'd1;
      DIR_RIGHT: col_next = col_reg + 4'd1;
      default:   ;
    endcase
    at_exit = (row_next == 4'(ROWS - 1)) && (col_next == 4'(COLS - 1));
  end

  // Round FSM with registered outputs; start outside IDLE/WON restarts generation and drops any move.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      gen_cnt_reg    <= '0;
      settle_reg     <= 1'b0;
      gen_rst_reg    <= 1'b1;
      ready_reg      <= 1'b0;
      won_reg        <= 1'b0;
      bump_reg       <= 1'b0;
      row_reg        <= '0;
      col_reg        <= '0;
      move_count_reg <= '0;
    end else begin
      bump_reg <= 1'b0;
      if (start) begin
        state_reg   <= GEN_RST;
        gen_cnt_reg <= GC_LOAD;
        gen_rst_reg <= 1'b1;
        ready_reg   <= 1'b0;
        won_reg     <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: gen_rst_reg <= 1'b1;
          GEN_RST: begin
            if (gen_cnt_reg == '0) begin
              state_reg   <= GEN_WAIT;
              gen_rst_reg <= 1'b0;
              settle_reg  <= 1'b1;
            end else begin
              gen_cnt_reg <= gen_cnt_reg - 1'b1;
            end
          end
          GEN_WAIT: begin
            if (settle_reg) begin
              settle_reg <= 1'b0;
            end else if (!gen_busy) begin
              state_reg      <= PLAY;
              ready_reg      <= 1'b1;
              row_reg        <= '0;
              col_reg        <= '0;
              move_count_reg <= '0;
            end
          end
          PLAY: begin
            if (move_valid) begin
              if (blocked) begin
                bump_reg <= 1'b1;
              end else begin
                row_reg <= row_next;
                col_reg <= col_next;
                if (move_count_reg != {CNT_W{1'b1}}) begin
                  move_count_reg <= move_count_reg + 1'b1;
                end
                if (at_exit) begin
                  state_reg <= WON;
                  ready_reg <= 1'b0;
                  won_reg   <= 1'b1;
                end
              end
            end
          end
          WON: ;
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign gen_rst    = gen_rst_reg;
  assign ready      = ready_reg;
  assign won        = won_reg;
  assign bump       = bump_reg;
  assign player_row = row_reg;
  assign player_col = col_reg;
  assign move_count = move_count_reg;

endmodule

// File: doc/maze_game_controller.md
Name: maze_game_controller

Overview:
- Top-level sequencer for one maze round.
- Holds maze_generator in reset for a fixed window, then waits for its busy flag to drop.
- Runs player movement on the 10x15 grid: accepts moves only through open walls, counts accepted moves and flags arrival at the exit cell.
- Sits between the input decoder and the maze_generator / display path.

Parameters:
- COLS, 10, maze width in cells.
- ROWS, 15, maze height in cells.
- GEN_RST_CYCLES, 4, cycles gen_rst is held high per generation.
- CNT_W, 16, width of the move counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse that begins a new round
- move_valid  in  1  move request strobe
- move_dir  in  2  0=up(row-1), 1=right(col+1), 2=down(row+1), 3=left(col-1)
- gen_busy  in  1  maze_generator busy flag
- h_walls  in  (ROWS+1)*COLS  horizontal walls; bit r*COLS+c is the wall above cell (r,c)
- v_walls  in  ROWS*(COLS+1)  vertical walls; bit r*(COLS+1)+c is the wall left of cell (r,c)
- gen_rst  out  1  active-high reset to maze_generator
- ready  out  1  high in PLAY only
- player_row  out  4  current row, 0..ROWS-1
- player_col  out  4  current column, 0..COLS-1
- move_count  out  CNT_W  accepted moves this round
- bump  out  1  one-cycle pulse when a move is rejected
- won  out  1  high in WON

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, gen_rst=1, ready=0, won=0, bump=0.
  - player_row=0, player_col=0, move_count=0.
- States and transitions:
  - IDLE: gen_rst=1. On start, go to GEN_RST and load the cycle counter.
  - GEN_RST: gen_rst=1 for exactly GEN_RST_CYCLES cycles, then go to GEN_WAIT with gen_rst=0.
  - GEN_WAIT: gen_rst=0. Ignore gen_busy on the first cycle (settle). From the second cycle on, gen_busy=0 moves to PLAY and clears position and count. No timeout.
  - PLAY: ready=1. The first cycle with move_valid=1 is evaluated; a registered result appears on the next edge (latency 1). At most one move is evaluated per cycle.
  - WON: won=1, moves ignored. Only start (or reset) leaves; start goes to GEN_RST.
- Move legality for cell (r,c), selecting the wall bit combinationally:
  - up: h[r*COLS+c]
  - down: h[(r+1)*COLS+c]
  - left: v[r*(COLS+1)+c]
  - right: v[r*(COLS+1)+c+1]
- A move is also illegal if it would leave the grid: r=0 up, r=ROWS-1 down, c=0 left, c=COLS-1 right. This bound check is independent of the wall bits.
- Legal move:
  - Update row/col.
  - move_count+1, saturating at all-ones.
  - If the new cell is (ROWS-1, COLS-1), enter WON the same edge.
- Illegal move: position and count unchanged, bump=1 for one cycle.
- move_valid outside PLAY: ignored, no bump.
- start in any state other than IDLE/WON (GEN_RST, GEN_WAIT, PLAY):
  - Restarts at GEN_RST.
  - Takes priority over a simultaneous move_valid; that move is dropped.
- Walls are sampled live. Wall bits are only meaningful while gen_busy=0; PLAY is entered only after that.
- rst assertion mid-round aborts immediately to the reset values.

Decomposition:
- Shared package maze_pkg:
  - constants MAZE_COLS=10, MAZE_ROWS=15
  - direction encodings DIR_UP/RIGHT/DOWN/LEFT
  - state enum IDLE/GEN_RST/GEN_WAIT/PLAY/WON
  - wall-index helper functions
- One sub-module: maze_wall_lookup.
  - Purely combinational.
  - Inputs: row, col, dir, h_walls, v_walls.
  - Output: blocked, covering both the wall bit and the bound check.
  - Reused later by the display/solver path.
- FSM, position registers and counter stay in maze_game_controller.

Test Plan:
1. Reset then start with gen_busy held 1 for 20 cycles -> gen_rst high exactly 4 cycles, ready stays 0 until the cycle after gen_busy falls, then ready=1, pos (0,0), count 0.
2. In PLAY at (0,0), move up -> bump=1 one cycle, pos (0,0), count 0. Move left -> same. Repeat with h/v walls forced all-zero -> still blocked (bound check).
3. All walls zero, move right 9 times then down 14 -> pos (14,9), count 23, won=1 on the edge of the 23rd move, ready=0. Further moves change nothing.
4. Wall v[0*11+1]=1, at (0,0) move right -> bump; clear the bit, move right -> pos (0,1), count 1.
5. start asserted in the same cycle as a legal move in PLAY -> move dropped, state GEN_RST, gen_rst=1. Then rst=0 mid-GEN_WAIT -> all outputs return to reset values immediately.
6. Preload move_count to 0xFFFE (force), two legal moves -> count 0xFFFF and held.
